// File: rtl/led_pio_blink_pkg.sv
// Shared constants for the LED PIO: register addresses, bus widths and the PWM gate.
package led_pio_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned BUS_W  = 32;
  localparam int unsigned DUTY_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_DATA   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_SET    = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_CLEAR  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_BLINK  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_DUTY   = 3'd5;

  localparam logic [DUTY_W-1:0] PWM_FULL = 8'hFF;

  // LEDs lit while the PWM counter is below DUTY; full duty never blanks.
  function automatic logic pwm_gate(input logic [DUTY_W-1:0] cnt,
                                    input logic [DUTY_W-1:0] duty);
    return (cnt < duty) || (duty == PWM_FULL);
  endfunction

endpackage

// File: rtl/led_pio_blink_if.sv
// Avalon-MM slave bus bundle for the LED PIO (zero-latency reads).
interface led_pio_blink_if;
  import led_pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [BUS_W-1:0]  writedata;
  logic [BUS_W-1:0]  readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/led_pio_blink_prescaler.sv
// Blink prescaler: phase toggles every PERIOD+1 cycles; a PERIOD write restarts it.
module led_pio_prescaler #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] period,
  input  logic             load,
  output logic             phase
);

  logic [CNT_W-1:0] cnt;

  // A load restarts from a clean low phase so a shrunk PERIOD takes effect at once.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == period) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_pio_blink.sv
// LED output PIO with set/clear, per-bit blink and prescaler.
// Optional PWM dimmer (DUTY register at address 5) enabled by LED_PIO_PWM_EN.
module led_pio_blink
  import led_pio_pkg::*;
#(
  parameter int unsigned      WIDTH   = 18,
  parameter int unsigned      CNT_W   = 24,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  led_pio_blink_if.slave   bus,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mask_q;
  logic [CNT_W-1:0] period_q;
  logic             phase;
  logic             wr;
  logic             period_load;
  logic [WIDTH-1:0] wd_led;
  logic [CNT_W-1:0] wd_cnt;
  logic [WIDTH-1:0] blink_out;
  logic             unused_wd;

  assign wr          = bus.chipselect && !bus.write_n;
  assign period_load = wr && (bus.address == ADDR_PERIOD);
  assign wd_led      = WIDTH'(bus.writedata);
  assign wd_cnt      = CNT_W'(bus.writedata);
  assign unused_wd   = ^bus.writedata;

`ifdef LED_PIO_PWM_EN
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] pwm_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_q    <= PWM_FULL;
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + DUTY_W'(1);
      if (wr && (bus.address == ADDR_DUTY)) duty_q <= DUTY_W'(bus.writedata);
    end
  end
`endif

  // Register file; only one register is addressed per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= RST_VAL;
      mask_q   <= '0;
      period_q <= '0;
    end else if (wr) begin
      case (bus.address)
        ADDR_DATA:   data_q   <= wd_led;
        ADDR_SET:    data_q   <= data_q | wd_led;
        ADDR_CLEAR:  data_q   <= data_q & ~wd_led;
        ADDR_BLINK:  mask_q   <= wd_led;
        ADDR_PERIOD: period_q <= wd_cnt;
        default:     ;
      endcase
    end
  end

  led_pio_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .period (period_q),
    .load   (period_load),
    .phase  (phase)
  );

  assign blink_out = (data_q & ~mask_q) | (data_q & mask_q & {WIDTH{phase}});

`ifdef LED_PIO_PWM_EN
  assign out_port = blink_out & {WIDTH{pwm_gate(pwm_cnt_q, duty_q)}};
`else
  assign out_port = blink_out;
`endif

  // Zero-latency read mux, zero-extended to the bus width.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:   bus.readdata = BUS_W'(data_q);
      ADDR_SET:    bus.readdata = BUS_W'(out_port);
      ADDR_BLINK:  bus.readdata = BUS_W'(mask_q);
      ADDR_PERIOD: bus.readdata = BUS_W'(period_q);
`ifdef LED_PIO_PWM_EN
      ADDR_DUTY:   bus.readdata = BUS_W'(duty_q);
`else
      ADDR_DUTY:   bus.readdata = '0;
`endif
      default:     bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pio_blink.sv
// Scoreboard bench for led_pio_blink; exercises the PWM path when LED_PIO_PWM_EN is defined.
module tb_led_pio_blink;
  import led_pio_pkg::*;

  localparam int unsigned WIDTH = 18;
  localparam int unsigned CNT_W = 24;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] out_port;

  led_pio_blink_if bus ();

  led_pio_blink #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RST_VAL(18'h0)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] sb_q[$];
  string       sb_n[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string n, input logic [31:0] v);
    sb_n.push_back(n);
    sb_q.push_back(v);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] obs[$];
    logic [31:0] rd, act, exp;
    string nm;
    reset = 1'b1;
    bus.address = ADDR_DATA; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = 32'h155;
    repeat (2) begin
      tick();
      sb_push("reset_out", 32'h0); obs.push_back(32'(out_port));
    end
    reset = 1'b0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    sb_push("reset_data_rd", 32'h0);   bus_rd(ADDR_DATA, rd);   obs.push_back(rd);
    sb_push("reset_blink_rd", 32'h0);  bus_rd(ADDR_BLINK, rd);  obs.push_back(rd);
    sb_push("reset_period_rd", 32'h0); bus_rd(ADDR_PERIOD, rd); obs.push_back(rd);
`ifdef LED_PIO_PWM_EN
    sb_push("reset_duty_rd", 32'hFF);
`else
    sb_push("reset_duty_rd", 32'h0);
`endif
    bus_rd(ADDR_DUTY, rd); obs.push_back(rd);
    bus_wr(ADDR_DATA, 32'h0003_FFFF);
    sb_push("data_out", 32'h3FFFF);    obs.push_back(32'(out_port));
    sb_push("data_rd", 32'h0003_FFFF); bus_rd(ADDR_DATA, rd); obs.push_back(rd);
    bus_wr(ADDR_DATA, 32'hFFFF_0000);
    sb_push("data_trunc_rd", 32'h0003_0000); bus_rd(ADDR_DATA, rd); obs.push_back(rd);
    while (obs.size() > 0) begin
      act = obs.pop_front(); exp = sb_q.pop_front(); nm = sb_n.pop_front();
      checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      else passed++;
    end
  endtask

  task automatic test_set_clear();
    logic [31:0] obs[$];
    logic [31:0] rd, act, exp;
    string nm;
    bus_wr(ADDR_DATA, 32'h00F0);
    bus_wr(ADDR_SET, 32'h000F);
    sb_push("set_rd", 32'h00FF);  bus_rd(ADDR_DATA, rd); obs.push_back(rd);
    sb_push("set_out", 32'h00FF); obs.push_back(32'(out_port));
    bus_wr(ADDR_CLEAR, 32'h0030);
    sb_push("clear_rd", 32'h00CF);   bus_rd(ADDR_DATA, rd);  obs.push_back(rd);
    sb_push("set_addr_rd", 32'h00CF); bus_rd(ADDR_SET, rd);  obs.push_back(rd);
    sb_push("clear_addr_rd", 32'h0); bus_rd(ADDR_CLEAR, rd); obs.push_back(rd);
    sb_push("clear_out", 32'h00CF);  obs.push_back(32'(out_port));
    while (obs.size() > 0) begin
      act = obs.pop_front(); exp = sb_q.pop_front(); nm = sb_n.pop_front();
      checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      else passed++;
    end
  endtask

  task automatic test_blink();
    logic [31:0] obs[$];
    logic [31:0] act, exp, mask, rd;
    logic        ph;
    string nm;
    bus_wr(ADDR_DATA, 32'h3);
    bus_wr(ADDR_BLINK, 32'h1);
    bus_wr(ADDR_PERIOD, 32'd3);
    for (int k = 0; k < 24; k++) begin
      if (k == 17) bus_wr(ADDR_BLINK, 32'h3);
      else if (k > 0) tick();
      mask = (k >= 17) ? 32'h3 : 32'h1;
      ph   = ((k / 4) % 2) == 1;
      exp  = (32'h3 & ~mask) | (32'h3 & mask & (ph ? 32'hFFFF_FFFF : 32'h0));
      sb_push($sformatf("blink_p3_k%0d", k), exp);
      obs.push_back(32'(out_port));
    end
    sb_push("blink_mask_rd", 32'h3); bus_rd(ADDR_BLINK, rd); obs.push_back(rd);
    bus_wr(ADDR_PERIOD, 32'd0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      sb_push($sformatf("blink_p0_k%0d", k), ((k % 2) == 1) ? 32'h3 : 32'h0);
      obs.push_back(32'(out_port));
    end
    while (obs.size() > 0) begin
      act = obs.pop_front(); exp = sb_q.pop_front(); nm = sb_n.pop_front();
      checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      else passed++;
    end
  endtask

  task automatic test_rewrite();
    logic [31:0] obs[$];
    logic [31:0] rd, act, exp;
    string nm;
    bus_wr(ADDR_PERIOD, 32'd1000);
    repeat (500) tick();
    sb_push("rewrite_mid", 32'h0); obs.push_back(32'(out_port));
    bus_wr(ADDR_PERIOD, 32'd2);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      sb_push($sformatf("rewrite_k%0d", k), (k == 3) ? 32'h3 : 32'h0);
      obs.push_back(32'(out_port));
    end
    sb_push("rewrite_period_rd", 32'd2); bus_rd(ADDR_PERIOD, rd); obs.push_back(rd);
    while (obs.size() > 0) begin
      act = obs.pop_front(); exp = sb_q.pop_front(); nm = sb_n.pop_front();
      checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      else passed++;
    end
  endtask

  task automatic test_reserved();
    logic [31:0] obs[$];
    logic [31:0] rd, act, exp;
    string nm;
    bus_wr(3'd6, 32'hDEAD_BEEF);
    bus_wr(3'd7, 32'h0000_0000);
`ifndef LED_PIO_PWM_EN
    bus_wr(ADDR_DUTY, 32'h12);
    sb_push("duty_absent_rd", 32'h0); bus_rd(ADDR_DUTY, rd); obs.push_back(rd);
`endif
    sb_push("rsvd_data_rd", 32'h3); bus_rd(ADDR_DATA, rd); obs.push_back(rd);
    sb_push("rsvd6_rd", 32'h0);     bus_rd(3'd6, rd);      obs.push_back(rd);
    sb_push("rsvd7_rd", 32'h0);     bus_rd(3'd7, rd);      obs.push_back(rd);
    bus_wr(ADDR_PERIOD, 32'hFFFF_FFFF);
    sb_push("period_trunc_rd", 32'h00FF_FFFF); bus_rd(ADDR_PERIOD, rd); obs.push_back(rd);
    sb_push("period_max_out", 32'h0); obs.push_back(32'(out_port));
    while (obs.size() > 0) begin
      act = obs.pop_front(); exp = sb_q.pop_front(); nm = sb_n.pop_front();
      checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      else passed++;
    end
  endtask

`ifdef LED_PIO_PWM_EN
  task automatic test_pwm();
    logic [31:0] obs[$];
    logic [31:0] rd, act, exp;
    logic [7:0]  duties[3];
    int          hi;
    string nm;
    duties[0] = 8'd64; duties[1] = 8'd0; duties[2] = 8'd255;
    bus_wr(ADDR_BLINK, 32'h0);
    bus_wr(ADDR_DATA, 32'h1);
    for (int i = 0; i < 3; i++) begin
      bus_wr(ADDR_DUTY, 32'(duties[i]));
      sb_push($sformatf("duty_rd_%0d", duties[i]), 32'(duties[i]));
      bus_rd(ADDR_DUTY, rd); obs.push_back(rd);
      hi = 0;
      repeat (256) begin
        tick();
        if (out_port[0]) hi++;
      end
      sb_push($sformatf("pwm_on_cycles_duty%0d", duties[i]),
              (duties[i] == 8'd255) ? 32'd256 : 32'(duties[i]));
      obs.push_back(32'(hi));
    end
    while (obs.size() > 0) begin
      act = obs.pop_front(); exp = sb_q.pop_front(); nm = sb_n.pop_front();
      checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      else passed++;
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] obs[$];
    logic [31:0] rd, act, exp;
    string nm;
    bus_wr(ADDR_PERIOD, 32'd0);
    bus_wr(ADDR_BLINK, 32'h3);
    bus_wr(ADDR_DATA, 32'h3);
`ifdef LED_PIO_PWM_EN
    bus_wr(ADDR_DUTY, 32'h40);
`endif
    repeat (3) tick();
    reset = 1'b1;
    bus.address = ADDR_BLINK; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = 32'h3FFFF;
    tick();
    reset = 1'b0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    sb_push("rmid_out", 32'h0);       obs.push_back(32'(out_port));
    sb_push("rmid_blink_rd", 32'h0);  bus_rd(ADDR_BLINK, rd);  obs.push_back(rd);
    sb_push("rmid_period_rd", 32'h0); bus_rd(ADDR_PERIOD, rd); obs.push_back(rd);
    sb_push("rmid_data_rd", 32'h0);   bus_rd(ADDR_DATA, rd);   obs.push_back(rd);
`ifdef LED_PIO_PWM_EN
    sb_push("rmid_duty_rd", 32'hFF);  bus_rd(ADDR_DUTY, rd);   obs.push_back(rd);
`endif
    // phase restarted at 0 and PERIOD=0 toggles it every edge after reset
    bus_wr(ADDR_DATA, 32'h1);
    bus_wr(ADDR_BLINK, 32'h1);
    sb_push("rmid_phase_r2", 32'h0); obs.push_back(32'(out_port));
    tick();
    sb_push("rmid_phase_r3", 32'h1); obs.push_back(32'(out_port));
    tick();
    sb_push("rmid_phase_r4", 32'h0); obs.push_back(32'(out_port));
    while (obs.size() > 0) begin
      act = obs.pop_front(); exp = sb_q.pop_front(); nm = sb_n.pop_front();
      checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      else passed++;
    end
  endtask

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    test_reset();
    test_set_clear();
    test_blink();
    test_rewrite();
    test_reserved();
`ifdef LED_PIO_PWM_EN
    test_pwm();
`endif
    test_reset_mid();
    checks++;
    if (sb_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
